// File: rtl/riscv_lsu_ctrl.sv
// Load/store sequencing controller: alignment and size checks, byte-lane steering,
// ready-handshake memory sequencing with timeout, and load-data extraction.
module riscv_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          r_state, w_state_next;
  logic            r_we;
  logic [3:0]      r_be;
  logic [31:0]     r_addr, r_wd, r_rd;
  logic [2:0]      r_size;
  logic [1:0]      r_off;
  logic [CntW-1:0] r_cnt;
  logic            r_misalign, r_fault;

  logic            w_legal, w_aligned;
  logic [3:0]      w_be;
  logic [31:0]     w_wd, w_shifted, w_load;
  logic            w_accept, w_misalign, w_illegal, w_capture, w_timeout;

  // Request decode: legality, alignment, byte enables and store lane replication.
  always_comb begin
    case (core_size_i)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~core_we_i;
      default:                w_legal = 1'b0;
    endcase
    w_aligned = 1'b1;
    w_be      = 4'b1111;
    w_wd      = core_wd_i;
    case (core_size_i[1:0])
      2'b00: begin
        w_be = 4'b0001 << core_addr_i[1:0];
        w_wd = {4{core_wd_i[7:0]}};
      end
      2'b01: begin
        w_aligned = ~core_addr_i[0];
        w_be      = 4'b0011 << {core_addr_i[1], 1'b0};
        w_wd      = {2{core_wd_i[15:0]}};
      end
      2'b10:   w_aligned = (core_addr_i[1:0] == 2'b00);
      default: ;
    endcase
  end

  // Load extraction from the word currently on mem_rd_i.
  always_comb begin
    w_shifted = mem_rd_i >> {r_off, 3'b000};
    case (r_size)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load = mem_rd_i;
      3'b100:  w_load = {24'd0, w_shifted[7:0]};
      3'b101:  w_load = {16'd0, w_shifted[15:0]};
      default: w_load = 32'd0;
    endcase
    if (r_we) w_load = 32'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_misalign   = 1'b0;
    w_illegal    = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    core_stall_o = 1'b0;
    case (r_state)
      StIdle: begin
        if (core_req_i) begin
          core_stall_o = 1'b1;
          if (!w_legal) begin
            w_illegal    = 1'b1;
            w_state_next = StDone;
          end else if (!w_aligned) begin
            w_misalign   = 1'b1;
            w_state_next = StDone;
          end else begin
            w_accept     = 1'b1;
            w_state_next = StBusy;
          end
        end
      end
      StBusy: begin
        core_stall_o = 1'b1;
        // Ready is checked first so a response in the final wait cycle still completes.
        if (mem_ready_i) begin
          w_capture    = 1'b1;
          w_state_next = StDone;
        end else if (TIMEOUT_CYCLES != 0 && (32'(r_cnt) + 32'd1 == TIMEOUT_CYCLES)) begin
          w_timeout    = 1'b1;
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we       <= 1'b0;
      r_be       <= 4'd0;
      r_addr     <= 32'd0;
      r_wd       <= 32'd0;
      r_size     <= 3'd0;
      r_off      <= 2'd0;
      r_cnt      <= '0;
      r_rd       <= 32'd0;
      r_misalign <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we   <= core_we_i;
        r_be   <= w_be;
        r_addr <= {core_addr_i[31:2], 2'b00};
        r_wd   <= w_wd;
        r_size <= core_size_i;
        r_off  <= core_addr_i[1:0];
        r_cnt  <= '0;
      end else if (r_state == StBusy && !mem_ready_i && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture) begin
        r_rd       <= w_load;
        r_misalign <= 1'b0;
        r_fault    <= 1'b0;
      end
      if (w_timeout || w_illegal) begin
        r_rd       <= 32'd0;
        r_misalign <= 1'b0;
        r_fault    <= 1'b1;
      end
      if (w_misalign) begin
        r_rd       <= 32'd0;
        r_misalign <= 1'b1;
        r_fault    <= 1'b0;
      end
    end
  end

  assign mem_req_o       = (r_state == StBusy);
  assign mem_we_o        = r_we & (r_state == StBusy);
  assign mem_be_o        = r_be;
  assign mem_addr_o      = r_addr;
  assign mem_wd_o        = r_wd;
  assign core_rd_o       = (r_state == StDone) ? r_rd : 32'd0;
  assign core_misalign_o = (r_state == StDone) & r_misalign;
  assign core_fault_o    = (r_state == StDone) & r_fault;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Directed bench for riscv_lsu_ctrl: an arithmetic model of each access drives a
// per-cycle compare process; literal expectations pin the model on the plan cases.
module tb_riscv_lsu_ctrl;

  localparam int unsigned T = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, core_misalign_o, core_fault_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
  logic        mem_ready_i;

  riscv_lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .core_req_i     (core_req_i),
    .core_we_i      (core_we_i),
    .core_size_i    (core_size_i),
    .core_addr_i    (core_addr_i),
    .core_wd_i      (core_wd_i),
    .core_rd_o      (core_rd_o),
    .core_stall_o   (core_stall_o),
    .core_misalign_o(core_misalign_o),
    .core_fault_o   (core_fault_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wd_o       (mem_wd_o),
    .mem_rd_i       (mem_rd_i),
    .mem_ready_i    (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model of the access in flight
  logic        txn_active = 1'b0;
  logic        m_we, m_mis, m_flt, m_noacc;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wd, m_rd;
  int          m_req_n, m_stall_n;

  task automatic model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] word, input int wait_n);
    int     nb;
    bit     legal, timed;
    longint v, mask;
    nb    = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
    legal = (size == 3'd0 || size == 3'd1 || size == 3'd2) ||
            ((size == 3'd4 || size == 3'd5) && !we);
    m_mis   = legal && ((addr % nb) != 0);
    m_noacc = !legal || m_mis;
    timed   = !m_noacc && (wait_n >= int'(T));
    m_flt   = !legal || timed;
    m_we    = we;
    m_addr  = addr & 32'hFFFF_FFFC;
    m_be    = 4'(((1 << nb) - 1) << ((addr % 4) - (addr % nb)));
    if (nb == 1)      m_wd = (wd & 32'hFF) * 32'h0101_0101;
    else if (nb == 2) m_wd = (wd & 32'hFFFF) * 32'h0001_0001;
    else              m_wd = wd;
    if (m_noacc || timed || we) m_rd = 32'd0;
    else if (nb == 4) m_rd = word;
    else begin
      mask = (64'd1 << (8 * nb)) - 1;
      v    = (longint'(word) >> (8 * (addr % 4))) & mask;
      if (!size[2] && ((v >> (8 * nb - 1)) & 1) == 1) v = v | ~mask;
      m_rd = 32'(v);
    end
    m_req_n   = m_noacc ? 0 : (timed ? int'(T) : wait_n + 1);
    m_stall_n = m_noacc ? 1 : m_req_n + 1;
  endtask

  // Per-cycle compare against the model while an access is in flight.
  always @(negedge clk_i) begin
    if (txn_active && rst_ni) begin
      if (mem_req_o) begin
        chk("no_access", {31'd0, m_noacc}, 32'd0);
        chk("mem_we", {31'd0, mem_we_o}, {31'd0, m_we});
        chk("mem_be", {28'd0, mem_be_o}, {28'd0, m_be});
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_wd", mem_wd_o, m_wd);
      end else if (!core_stall_o) begin
        chk("done_rd", core_rd_o, m_rd);
        chk("done_misalign", {31'd0, core_misalign_o}, {31'd0, m_mis});
        chk("done_fault", {31'd0, core_fault_o}, {31'd0, m_flt});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 following DONE so accesses run back-to-back.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] word, input int wait_n,
                        input bit drop_req, output logic [31:0] rd_got, output logic mis_got,
                        output logic flt_got, output logic [3:0] be_got,
                        output logic [31:0] wd_got);
    int stall_n = 0;
    int req_n = 0;
    bit done = 1'b0;
    rd_got = 'x; mis_got = 'x; flt_got = 'x; be_got = 'x; wd_got = 'x;
    model(we, size, addr, wd, word, wait_n);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_rd_i    = word;
    mem_ready_i = 1'b0;
    txn_active  = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk_i);
      if (core_stall_o) stall_n++;
      if (mem_req_o) begin
        req_n++;
        be_got = mem_be_o;
        wd_got = mem_wd_o;
        if (req_n > wait_n) mem_ready_i = 1'b1;
        if (drop_req) core_req_i = 1'b0;
      end else if (!core_stall_o) begin
        done       = 1'b1;
        rd_got     = core_rd_o;
        mis_got    = core_misalign_o;
        flt_got    = core_fault_o;
        core_req_i = 1'b0;
      end
      @(posedge clk_i);
      #1 mem_ready_i = 1'b0;
      if (done) break;
    end
    txn_active = 1'b0;
    core_req_i = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("stall_cycles", stall_n, m_stall_n);
    chk("req_cycles", req_n, m_req_n);
  endtask

  logic [31:0] rd, wdg;
  logic        mis, flt;
  logic [3:0]  be;

  initial begin
    rst_ni      = 1'b0;
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = 32'd0;
    core_wd_i   = 32'd0;
    mem_rd_i    = 32'd0;
    mem_ready_i = 1'b0;
    #2;
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wd", mem_wd_o, 32'd0);
    chk("rst_rd", core_rd_o, 32'd0);
    chk("rst_flags", {30'd0, core_misalign_o, core_fault_o}, 32'd0);
    chk("rst_stall_idle", {31'd0, core_stall_o}, 32'd0);
    core_req_i = 1'b1;
    #1 chk("rst_stall_req", {31'd0, core_stall_o}, 32'd1);
    core_req_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    access(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1'b0, rd, mis, flt, be, wdg);
    chk("lw_rd_lit", rd, 32'hDEADBEEF);
    chk("lw_be_lit", {28'd0, be}, 32'hF);
    access(1'b0, 3'b000, 32'h203, 32'd0, 32'h80FF7F01, 0, 1'b0, rd, mis, flt, be, wdg);
    chk("lb_rd_lit", rd, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h203, 32'd0, 32'h80FF7F01, 1, 1'b0, rd, mis, flt, be, wdg);
    chk("lbu_rd_lit", rd, 32'h00000080);
    access(1'b0, 3'b001, 32'h202, 32'd0, 32'h80FF7F01, 0, 1'b0, rd, mis, flt, be, wdg);
    chk("lh_rd_lit", rd, 32'hFFFF80FF);
    access(1'b0, 3'b101, 32'h202, 32'd0, 32'h80FF7F01, 0, 1'b0, rd, mis, flt, be, wdg);
    chk("lhu_rd_lit", rd, 32'h000080FF);
    access(1'b0, 3'b000, 32'h201, 32'd0, 32'h80FF7F01, 0, 1'b0, rd, mis, flt, be, wdg);
    chk("lb1_rd_lit", rd, 32'h0000007F);
    access(1'b1, 3'b000, 32'h3, 32'h12345678, 32'd0, 0, 1'b0, rd, mis, flt, be, wdg);
    chk("sb_be_lit", {28'd0, be}, 32'h8);
    chk("sb_wd_lit", wdg, 32'h78787878);
    chk("sb_rd_lit", rd, 32'd0);
    access(1'b1, 3'b001, 32'h2, 32'h12345678, 32'd0, 2, 1'b0, rd, mis, flt, be, wdg);
    chk("sh_be_lit", {28'd0, be}, 32'hC);
    chk("sh_wd_lit", wdg, 32'h56785678);
    access(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'd0, 0, 1'b0, rd, mis, flt, be, wdg);
    chk("sw_wd_lit", wdg, 32'hCAFEF00D);
    access(1'b0, 3'b010, 32'h102, 32'd0, 32'h11111111, 0, 1'b0, rd, mis, flt, be, wdg);
    chk("misalign_lit", {31'd0, mis}, 32'd1);
    access(1'b1, 3'b100, 32'h100, 32'h1, 32'd0, 0, 1'b0, rd, mis, flt, be, wdg);
    chk("illegal_fault_lit", {31'd0, flt}, 32'd1);
    access(1'b0, 3'b111, 32'h100, 32'h1, 32'd0, 0, 1'b0, rd, mis, flt, be, wdg);
    chk("illegal_size_lit", {31'd0, flt}, 32'd1);
    access(1'b0, 3'b010, 32'h104, 32'd0, 32'hA5A5_0001, 3, 1'b1, rd, mis, flt, be, wdg);
    chk("wait3_rd_lit", rd, 32'hA5A5_0001);
    access(1'b0, 3'b010, 32'h108, 32'd0, 32'h1234_5678, 100, 1'b0, rd, mis, flt, be, wdg);
    chk("timeout_fault_lit", {31'd0, flt}, 32'd1);
    chk("timeout_rd_lit", rd, 32'd0);
    access(1'b0, 3'b010, 32'h10C, 32'd0, 32'h0BAD_F00D, 15, 1'b0, rd, mis, flt, be, wdg);
    chk("last_cycle_ready_fault", {31'd0, flt}, 32'd0);
    chk("last_cycle_ready_rd", rd, 32'h0BAD_F00D);

    // Reset in the middle of a BUSY wait.
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'b010;
    core_addr_i = 32'h40;
    mem_ready_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("busy_before_rst", {31'd0, mem_req_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1 chk("rst_async_req", {31'd0, mem_req_o}, 32'd0);
    core_req_i = 1'b0;
    #1 chk("rst_stall_drop", {31'd0, core_stall_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    access(1'b0, 3'b010, 32'h44, 32'd0, 32'h5555_AAAA, 0, 1'b0, rd, mis, flt, be, wdg);
    chk("after_rst_rd", rd, 32'h5555_AAAA);

    repeat (2) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
